// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB plus a terminal HALT.
// FETCH and MEM wait for the memory ready handshake; a bounded wait counter raises a
// sticky timeout and parks the sequencer in HALT.
// Optional build macro MULTICYCLE_ILLEGAL_TRAP_EN: illegal opcodes halt and set the sticky
// `illegal` output instead of running as a NOP.
module multicycle_control #(
   parameter int unsigned WAIT_LIMIT = 16,
   parameter int unsigned CNT_W      = 5
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic [10:0] opcode,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        zero,
   output logic        imem_req,
   output logic        irwrite,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic        regwrite,
   output logic        reg2loc,
   output logic        alusrc,
   output logic        mem2reg,
   output logic [3:0]  aluop,
   output logic [2:0]  signop,
   output logic        pcwrite,
   output logic        pcsrc,
   output logic        timeout,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
   output logic        illegal,
`endif
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StHalt   = 3'd6
   } state_e;

   typedef enum logic [3:0] {
      ClsAnd, ClsOrr, ClsAdd, ClsSub, ClsAddi, ClsSubi,
      ClsMovz, ClsB, ClsCbz, ClsLdur, ClsStur, ClsIll
   } cls_e;

   // Last counter value that may still be spent waiting; one more miss times out.
   localparam logic [CNT_W-1:0] LimM1 = CNT_W'(WAIT_LIMIT - 1);

   state_e           state_q, state_d;
   cls_e             cls_q, cls_d, dec_cls;
   logic [1:0]       hh_q, hh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             illegal_q, illegal_d;
   logic             wait_hit;

   assign wait_hit = (WAIT_LIMIT != 0) && (cnt_q == LimM1);
   assign state    = state_q;
   assign timeout  = timeout_q;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
   assign illegal  = illegal_q;
`endif

   // Opcode class decode; overlapping patterns resolve by first match.
   always_comb begin
      dec_cls = ClsIll;
      casez (opcode)
         11'b?0001010???: dec_cls = ClsAnd;
         11'b?0101010???: dec_cls = ClsOrr;
         11'b?0?01011???: dec_cls = ClsAdd;
         11'b?1?01011???: dec_cls = ClsSub;
         11'b?0?10001???: dec_cls = ClsAddi;
         11'b?1?10001???: dec_cls = ClsSubi;
         11'b110100101??: dec_cls = ClsMovz;
         11'b?00101?????: dec_cls = ClsB;
         11'b?011010????: dec_cls = ClsCbz;
         11'b??111000010: dec_cls = ClsLdur;
         11'b??111000000: dec_cls = ClsStur;
         default:         dec_cls = ClsIll;
      endcase
   end

   // Next-state, wait counter, sticky flags and per-state strobes.
   always_comb begin
      state_d    = state_q;
      cls_d      = cls_q;
      hh_d       = hh_q;
      cnt_d      = cnt_q;
      timeout_d  = timeout_q;
      illegal_d  = illegal_q;
      imem_req   = 1'b0;
      irwrite    = 1'b0;
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      regwrite   = 1'b0;
      pcwrite    = 1'b0;
      pcsrc      = 1'b0;

      case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               irwrite = 1'b1;
               state_d = StDecode;
            end else if (wait_hit) begin
               state_d   = StHalt;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDecode: begin
            cls_d   = dec_cls;
            hh_d    = opcode[1:0];
            state_d = StExec;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            if (dec_cls == ClsIll) begin
               state_d   = StHalt;
               illegal_d = 1'b1;
            end
`endif
         end
         StExec: begin
            case (cls_q)
               ClsB: begin
                  pcwrite = 1'b1;
                  pcsrc   = 1'b1;
                  state_d = StFetch;
               end
               ClsCbz: begin
                  pcwrite = 1'b1;
                  pcsrc   = zero;
                  state_d = StFetch;
               end
               ClsIll: begin
                  // Illegal opcodes retire as a NOP: just advance the PC.
                  pcwrite = 1'b1;
                  state_d = StFetch;
               end
               ClsLdur, ClsStur: state_d = StMem;
               default:          state_d = StWb;
            endcase
         end
         StMem: begin
            dmem_read  = (cls_q == ClsLdur);
            dmem_write = (cls_q != ClsLdur);
            if (dmem_ready) begin
               if (cls_q == ClsLdur) begin
                  state_d = StWb;
               end else begin
                  // Stores retire in the handshake cycle.
                  pcwrite = 1'b1;
                  state_d = StFetch;
               end
            end else if (wait_hit) begin
               state_d   = StHalt;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWb: begin
            regwrite = 1'b1;
            pcwrite  = 1'b1;
            state_d  = StFetch;
         end
         StHalt:  state_d = StHalt;
         default: state_d = StIdle;
      endcase

      if ((state_d == StFetch || state_d == StMem) && state_d != state_q) begin
         cnt_d = '0;
      end
   end

   // Datapath selects, held for the whole EXEC..retire window of an instruction.
   always_comb begin
      reg2loc = 1'b0;
      alusrc  = 1'b0;
      mem2reg = 1'b0;
      aluop   = 4'b0000;
      signop  = 3'b000;
      if (state_q == StExec || state_q == StMem || state_q == StWb) begin
         case (cls_q)
            ClsAnd:  aluop = 4'b0000;
            ClsOrr:  aluop = 4'b0001;
            ClsAdd:  aluop = 4'b0010;
            ClsSub:  aluop = 4'b0110;
            ClsAddi: begin
               aluop  = 4'b0010;
               alusrc = 1'b1;
            end
            ClsSubi: begin
               aluop  = 4'b0110;
               alusrc = 1'b1;
            end
            ClsLdur: begin
               aluop   = 4'b0010;
               alusrc  = 1'b1;
               signop  = 3'b001;
               mem2reg = 1'b1;
            end
            ClsStur: begin
               aluop   = 4'b0010;
               alusrc  = 1'b1;
               signop  = 3'b001;
               reg2loc = 1'b1;
            end
            ClsMovz: begin
               aluop  = 4'b0111;
               alusrc = 1'b1;
               signop = {1'b1, hh_q};
            end
            ClsCbz: begin
               aluop   = 4'b0111;
               reg2loc = 1'b1;
               signop  = 3'b011;
            end
            ClsB:    signop = 3'b010;
            default: aluop = 4'b0000;
         endcase
      end
   end

   // State, class and flag registers; reset aborts any instruction in flight.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q   <= StIdle;
         cls_q     <= ClsIll;
         hh_q      <= 2'b00;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         hh_q      <= hh_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         illegal_q <= illegal_d;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised bench for multicycle_control: a per-instruction reference model derived from the
// instruction class table and path descriptions drives expectations checked every cycle.
module tb_multicycle_control;

   localparam int WL = 16;

   localparam int CAND = 0, CORR = 1, CADD = 2, CSUB = 3, CADDI = 4, CSUBI = 5;
   localparam int CMOVZ = 6, CB = 7, CCBZ = 8, CLDUR = 9, CSTUR = 10, CILL = 11;

   logic        CLK = 1'b0;
   logic        resetl;
   logic [10:0] opcode;
   logic        imem_ready, dmem_ready, zero;
   logic        imem_req, irwrite, dmem_read, dmem_write, regwrite;
   logic        reg2loc, alusrc, mem2reg, pcwrite, pcsrc, timeout;
   logic [3:0]  aluop;
   logic [2:0]  signop, state;
   logic        ill_bit;

   multicycle_control #(.WAIT_LIMIT(WL), .CNT_W(5)) dut (
      .CLK        (CLK),
      .resetl     (resetl),
      .opcode     (opcode),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .zero       (zero),
      .imem_req   (imem_req),
      .irwrite    (irwrite),
      .dmem_read  (dmem_read),
      .dmem_write (dmem_write),
      .regwrite   (regwrite),
      .reg2loc    (reg2loc),
      .alusrc     (alusrc),
      .mem2reg    (mem2reg),
      .aluop      (aluop),
      .signop     (signop),
      .pcwrite    (pcwrite),
      .pcsrc      (pcsrc),
      .timeout    (timeout),
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      .illegal    (ill_bit),
`endif
      .state      (state)
   );
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
   assign ill_bit = 1'b0;
`endif

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [2:0] state;
      logic       imem_req;
      logic       irwrite;
      logic       dmem_read;
      logic       dmem_write;
      logic       regwrite;
      logic       reg2loc;
      logic       alusrc;
      logic       mem2reg;
      logic [3:0] aluop;
      logic [2:0] signop;
      logic       pcwrite;
      logic       pcsrc;
      logic       timeout;
      logic       illegal;
   } outs_t;

   outs_t got, exp_o;
   bit    exp_valid = 1'b0;
   assign got = {state, imem_req, irwrite, dmem_read, dmem_write, regwrite, reg2loc, alusrc,
                 mem2reg, aluop, signop, pcwrite, pcsrc, timeout, ill_bit};

   int total = 0;
   int bad = 0;
   int cyc = 0;
   string       q_name[$];
   logic [31:0] q_got[$];
   logic [31:0] q_want[$];

   // Model state: sticky flags and whether the sequencer is parked in HALT.
   bit to_flag = 1'b0;
   bit ill_flag = 1'b0;
   bit halted = 1'b0;

   string pat [11] = '{"?0001010???", "?0101010???", "?0?01011???", "?1?01011???",
                       "?0?10001???", "?1?10001???", "110100101hh", "?00101?????",
                       "?011010????", "??111000010", "??111000000"};

   // The single checker: queued point checks plus the per-cycle model comparison.
   always @(negedge CLK) begin
      cyc++;
      while (q_name.size() > 0) begin
         string       n;
         logic [31:0] g, w;
         n = q_name.pop_front();
         g = q_got.pop_front();
         w = q_want.pop_front();
         total++;
         if (g !== w) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, g, w);
         end
      end
      if (exp_valid) begin
         total++;
         if (got !== exp_o) begin
            bad++;
            $display("FAIL cycle %0d outputs: got %h want %h (st=%0d/%0d)", cyc, got, exp_o,
                     got.state, exp_o.state);
         end
      end
   end

   task automatic pin(input string n, input logic [31:0] g, input logic [31:0] w);
      q_name.push_back(n);
      q_got.push_back(g);
      q_want.push_back(w);
   endtask

   function automatic int classify(input logic [10:0] op);
      for (int k = 0; k < 11; k++) begin
         string p;
         bit    ok;
         p  = pat[k];
         ok = 1'b1;
         for (int j = 0; j < 11; j++) begin
            if ((p[j] == "0" && op[10-j]) || (p[j] == "1" && !op[10-j])) ok = 1'b0;
         end
         if (ok) return k;
      end
      return CILL;
   endfunction

   function automatic logic [10:0] make_op(input int k);
      string       p;
      logic [10:0] op;
      p  = pat[k];
      op = 11'($urandom);
      for (int j = 0; j < 11; j++) begin
         if (p[j] == "0") op[10-j] = 1'b0;
         if (p[j] == "1") op[10-j] = 1'b1;
      end
      return op;
   endfunction

   function automatic outs_t base(input int st);
      outs_t e;
      e         = '0;
      e.state   = 3'(st);
      e.timeout = to_flag;
      e.illegal = ill_flag;
      return e;
   endfunction

   function automatic outs_t with_sel(input outs_t ei, input int cls, input logic [10:0] op);
      outs_t e;
      e = ei;
      case (cls)
         CORR:  e.aluop = 4'b0001;
         CADD:  e.aluop = 4'b0010;
         CSUB:  e.aluop = 4'b0110;
         CADDI: begin e.aluop = 4'b0010; e.alusrc = 1'b1; end
         CSUBI: begin e.aluop = 4'b0110; e.alusrc = 1'b1; end
         CLDUR: begin e.aluop = 4'b0010; e.alusrc = 1'b1; e.signop = 3'b001; e.mem2reg = 1'b1; end
         CSTUR: begin e.aluop = 4'b0010; e.alusrc = 1'b1; e.signop = 3'b001; e.reg2loc = 1'b1; end
         CMOVZ: begin e.aluop = 4'b0111; e.alusrc = 1'b1; e.signop = {1'b1, op[1:0]}; end
         CCBZ:  begin e.aluop = 4'b0111; e.reg2loc = 1'b1; e.signop = 3'b011; end
         CB:    e.signop = 3'b010;
         default: ;
      endcase
      return e;
   endfunction

   task automatic noise();
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      zero       = 1'($urandom);
   endtask

   task automatic tick(input outs_t e);
      exp_o     = e;
      exp_valid = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   // Hold reset, release it away from the clock edge, and step through IDLE into FETCH.
   task automatic do_reset();
      exp_valid = 1'b0;
      resetl    = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      pin("reset state", 32'(state), 32'd0);
      pin("reset timeout", 32'(timeout), 32'd0);
      to_flag  = 1'b0;
      ill_flag = 1'b0;
      halted   = 1'b0;
      resetl   = 1'b1;
      noise();
      tick(base(0));
   endtask

   task automatic halt_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         noise();
         tick(base(6));
      end
   endtask

   // Walk one instruction from FETCH; ird/drd = cycles without ready before the handshake.
   task automatic run_instr(input logic [10:0] op, input int ird, input int drd, input logic z,
                            input int abort_at, output int ncyc);
      int    cls, i;
      bit    done;
      outs_t e;
      cls  = classify(op);
      ncyc = 0;
      i    = 0;
      done = 1'b0;
      while (!done) begin
         noise();
         opcode     = 11'($urandom);
         imem_ready = (i == ird);
         e          = base(1);
         e.imem_req = 1'b1;
         e.irwrite  = imem_ready;
         tick(e);
         ncyc++;
         if (imem_ready) done = 1'b1;
         else if (WL != 0 && i == WL - 1) begin
            to_flag = 1'b1;
            halted  = 1'b1;
            return;
         end
         i++;
      end
      noise();
      opcode = op;
      tick(base(2));
      ncyc++;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      if (cls == CILL) begin
         ill_flag = 1'b1;
         halted   = 1'b1;
         return;
      end
`endif
      noise();
      zero = z;
      e    = with_sel(base(3), cls, op);
      if (cls == CB)   begin e.pcwrite = 1'b1; e.pcsrc = 1'b1; end
      if (cls == CCBZ) begin e.pcwrite = 1'b1; e.pcsrc = z; end
      if (cls == CILL) e.pcwrite = 1'b1;
      tick(e);
      ncyc++;
      if (cls == CB || cls == CCBZ || cls == CILL) return;
      if (cls == CLDUR || cls == CSTUR) begin
         i    = 0;
         done = 1'b0;
         while (!done) begin
            noise();
            dmem_ready   = (i == drd);
            e            = with_sel(base(4), cls, op);
            e.dmem_read  = (cls == CLDUR);
            e.dmem_write = (cls == CSTUR);
            if (i == abort_at) begin
               exp_valid = 1'b0;
               pin("dmem_write before abort", 32'(dmem_write), 32'(cls == CSTUR));
               resetl = 1'b0;
               #1;
               pin("state after async reset", 32'(state), 32'd0);
               pin("dmem_write after async reset", 32'(dmem_write), 32'd0);
               pin("pcwrite after async reset", 32'(pcwrite), 32'd0);
               do_reset();
               ncyc = -1;
               return;
            end
            if (dmem_ready && cls == CSTUR) e.pcwrite = 1'b1;
            tick(e);
            ncyc++;
            if (dmem_ready) done = 1'b1;
            else if (WL != 0 && i == WL - 1) begin
               to_flag = 1'b1;
               halted  = 1'b1;
               return;
            end
            i++;
         end
         if (cls == CSTUR) return;
      end
      noise();
      e          = with_sel(base(5), cls, op);
      e.regwrite = 1'b1;
      e.pcwrite  = 1'b1;
      tick(e);
      ncyc++;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k, ird, drd;
      logic [10:0] op;
      resetl     = 1'b0;
      opcode     = '0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      zero       = 1'b0;
      #12;
      pin("reset imem_req", 32'(imem_req), 32'd0);
      pin("reset pcwrite", 32'(pcwrite), 32'd0);
      do_reset();

      pin("classify ADD", 32'(classify(11'b10001011000)), 32'(CADD));
      pin("classify CBZ", 32'(classify(11'b10110100111)), 32'(CCBZ));
      run_instr(11'b10001011000, 0, 0, 1'b0, -1, n);
      pin("ADD latency", 32'(n), 32'd4);
      run_instr(11'b11111000010, 0, 3, 1'b0, -1, n);
      pin("LDUR latency with 3-cycle wait", 32'(n), 32'd8);
      run_instr(11'b10110100101, 0, 0, 1'b1, -1, n);
      pin("CBZ taken latency", 32'(n), 32'd3);
      run_instr(11'b10110100010, 0, 0, 1'b0, -1, n);
      run_instr(11'b11111000000, 0, 0, 1'b0, -1, n);
      pin("STUR latency", 32'(n), 32'd4);
      run_instr(11'b11010010110, 0, 0, 1'b0, -1, n);
      run_instr(11'b00010100000, 0, 0, 1'b0, -1, n);
      pin("B latency", 32'(n), 32'd3);
      run_instr(11'b10001011000, WL - 1, 0, 1'b0, -1, n);
      pin("ready in last allowed fetch cycle", 32'(n), 32'(WL + 3));
      run_instr(11'b11111000010, 0, WL - 1, 1'b0, -1, n);
      pin("ready in last allowed mem cycle", 32'(halted), 32'd0);

      run_instr(11'b11111000000, 0, 100, 1'b0, 2, n);
      run_instr(11'b10001011000, 1, 0, 1'b0, -1, n);
      pin("fetch after abort", 32'(n), 32'd5);

      run_instr(11'b00000000000, 0, 0, 1'b0, -1, n);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      pin("illegal halts", 32'(halted), 32'd1);
      halt_cycles(4);
      pin("illegal sticky", 32'(ill_bit), 32'd1);
      do_reset();
`else
      pin("illegal NOP latency", 32'(n), 32'd3);
`endif

      run_instr(11'b11111000000, 0, 100, 1'b0, -1, n);
      pin("STUR timeout after WL mem cycles", 32'(n), 32'(WL + 3));
      halt_cycles(6);
      pin("timeout sticky", 32'(timeout), 32'd1);
      pin("halt state", 32'(state), 32'd6);
      do_reset();

      for (int t = 0; t < 300; t++) begin
         k   = $urandom_range(0, 11);
         op  = (k < 11) ? make_op(k) : 11'($urandom);
         ird = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
         drd = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
         run_instr(op, ird, drd, 1'($urandom), -1, n);
         if (halted) begin
            halt_cycles(3);
            do_reset();
         end
      end

      exp_valid = 1'b0;
      @(negedge CLK);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the LEGv8 datapath. Replaces the single-cycle decoder when instruction and data memories have variable latency.
- Walks each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB.
- Holds in FETCH and MEM until the memory ready handshake arrives.
- Asserts per-state datapath enables. The PC updates exactly once per instruction, in its final cycle.

Parameters:
- WAIT_LIMIT, 16: max cycles in FETCH or MEM without ready before timeout; 0 disables timeout.
- CNT_W, 5: width of wait counter; must hold WAIT_LIMIT.

Ports:
- CLK  in  1  clock, rising edge.
- resetl  in  1  asynchronous, active-low reset.
- opcode  in  11  IR[31:21]; valid from DECODE onward.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- zero  in  1  ALU zero flag (CBZ).
- imem_req  out  1  instruction fetch request.
- irwrite  out  1  load IR.
- dmem_read  out  1  data read request.
- dmem_write  out  1  data write request.
- regwrite  out  1  register file write.
- reg2loc, alusrc, mem2reg  out  1 each  datapath mux selects.
- aluop  out  4  ALU operation.
- signop  out  3  sign-extender mode.
- pcwrite  out  1  PC load strobe.
- pcsrc  out  1  1 = branch target, 0 = PC+4.
- timeout  out  1  sticky memory timeout flag.
- state  out  3  debug: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.

Behaviour:
- Reset:
  - Asynchronous on resetl low: state=IDLE, wait counter=0, timeout=0.
  - All outputs are 0 in IDLE and HALT.
  - Reset mid-instruction aborts immediately; no pcwrite/regwrite/dmem_write is issued.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- FETCH:
  - imem_req=1 every cycle.
  - On imem_ready: irwrite=1 in that same cycle, then -> DECODE.
- DECODE:
  - One cycle; opcode is sampled into an internal class register, then -> EXEC.
  - Class decode (casez), priority top to bottom:
    - ANDREG ?0001010???
    - ORRREG ?0101010???
    - ADDREG ?0?01011???
    - SUBREG ?1?01011???
    - ADDIMM ?0?10001???
    - SUBIMM ?1?10001???
    - MOVZ 110100101hh
    - B ?00101?????
    - CBZ ?011010????
    - LDUR ??111000010
    - STUR ??111000000
    - otherwise ILLEGAL.
- EXEC/MEM/WB mux and ALU values, held constant from EXEC through the last cycle:
  - AND: aluop 0000. ORR: aluop 0001. ADD: 0010. SUB: 0110. All four: alusrc=0, reg2loc=0.
  - ADDIMM/SUBIMM: aluop 0010/0110, alusrc=1, signop=000.
  - LDUR/STUR: aluop 0010, alusrc=1, signop=001. STUR adds reg2loc=1.
  - MOVZ: aluop 0111, alusrc=1, signop = 1,hh.
  - CBZ: aluop 0111, reg2loc=1, signop=011.
  - B: signop=010.
  - mem2reg=1 for LDUR only. All unlisted selects are 0.
- Paths:
  - R-type, imm and MOVZ: EXEC -> WB; WB asserts regwrite=1 and pcwrite=1 (pcsrc=0) -> FETCH.
  - LDUR: EXEC -> MEM. dmem_read=1 until dmem_ready, then -> WB. WB asserts regwrite, pcwrite -> FETCH.
  - STUR: EXEC -> MEM. dmem_write=1 until dmem_ready; the dmem_ready cycle asserts pcwrite=1 -> FETCH.
  - B: EXEC asserts pcwrite=1, pcsrc=1 -> FETCH.
  - CBZ: EXEC asserts pcwrite=1, pcsrc=zero -> FETCH.
- Latencies with immediate ready: ALU ops 4 cycles, LDUR 5, STUR 4, B/CBZ 3.
- Ready arriving in the entry cycle of FETCH/MEM is accepted with no extra wait.
- Ready asserted outside FETCH/MEM is ignored.
- Wait counter:
  - Clears on entry to FETCH/MEM; increments each cycle in FETCH/MEM without ready.
  - If WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT with no ready: -> HALT, timeout=1.
  - A ready arriving in that same cycle wins; no timeout.
- HALT is terminal until reset.

Optional Feature:
- Macro MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: ILLEGAL class in DECODE -> HALT; an extra output `illegal` is set sticky; no pcwrite.
- Undefined: ILLEGAL executes as NOP, DECODE -> EXEC, where EXEC asserts pcwrite=1, pcsrc=0 -> FETCH. No regwrite or memory access; no `illegal` port.

Test Plan:
- Reset release, imem_ready=1, opcode=10001011000 (ADD) -> state 0,1,2,3,5,1; irwrite in FETCH; regwrite=1 and pcwrite=1 only in WB; aluop=0010.
- LDUR opcode 11111000010, dmem_ready delayed 3 cycles -> dmem_read high exactly 4 MEM cycles; mem2reg=1 and regwrite=1 in WB; pcwrite once.
- CBZ 10110100xxx with zero=1, then zero=0 -> EXEC pcwrite=1 with pcsrc=1, then pcsrc=0; regwrite never set.
- STUR with dmem_ready held low, WAIT_LIMIT=16 -> after 16 MEM cycles state=6, timeout=1, all outputs 0; ready pulse arriving later ignored.
- resetl pulsed low during MEM of STUR -> state=0 asynchronously, dmem_write drops without a clock edge; next instruction fetches cleanly.
- opcode 00000000000 -> with macro: HALT, illegal=1; without macro: 3-cycle NOP with pcwrite=1, pcsrc=0.
